// File: rtl/pmp_types_1_12_pkg.sv
// PMP shared types: access kinds, cfg byte layout, checker FSM states and the NAPOT mask helper.
package pmp_types_1_12_pkg;

  typedef logic [31:0] pmpaddr_t;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'd0,
    PMP_TOR   = 2'd1,
    PMP_NA4   = 2'd2,
    PMP_NAPOT = 2'd3
  } pmp_mode_t;

  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_mode_t a;
    logic      x;
    logic      w;
    logic      r;
  } pmpcfg_base_t;

  typedef enum logic [1:0] {
    ACC_R = 2'd0,
    ACC_W = 2'd1,
    ACC_X = 2'd2
  } pmp_access_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } pmp_fsm_t;

  // Bits set in the result are "don't care" bits of a NAPOT region; all-ones pmpaddr yields all-ones.
  function automatic pmpaddr_t pmp_napot_mask(input pmpaddr_t addr);
    return addr ^ (addr + 32'd1);
  endfunction

endpackage

// File: rtl/pmp_serial_checker_if.sv
// Request/response bus between the memory-request path and the serial PMP checker.
interface pmp_serial_checker_if #(
  parameter int IDX_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic [1:0]       req_acc;
  logic             req_priv_m;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_fault;
  logic             resp_match;
  logic [IDX_W-1:0] resp_idx;

  modport master (
    output req_valid, req_addr, req_acc, req_priv_m, resp_ready,
    input  req_ready, resp_valid, resp_fault, resp_match, resp_idx
  );

  modport slave (
    input  req_valid, req_addr, req_acc, req_priv_m, resp_ready,
    output req_ready, resp_valid, resp_fault, resp_match, resp_idx
  );
endinterface

// File: rtl/pmp_entry_match.sv
// Single-entry PMP address match and permission evaluation (purely combinational).
module pmp_entry_match
  import pmp_types_1_12_pkg::*;
(
  input  logic [31:0]  a,
  input  pmpaddr_t     prev_addr,
  input  pmpcfg_base_t cfg,
  input  pmpaddr_t     pmpaddr,
  input  logic [1:0]   acc,
  input  logic         priv_m,
  output logic         match,
  output logic         perm_ok
);

  pmpaddr_t w_mask;
  logic     w_perm;

  always_comb begin
    w_mask = pmp_napot_mask(pmpaddr);
    match  = 1'b0;
    case (cfg.a)
      PMP_TOR:   match = (a >= prev_addr) && (a < pmpaddr);
      PMP_NA4:   match = (a == pmpaddr);
      PMP_NAPOT: match = ((a & ~w_mask) == (pmpaddr & ~w_mask));
      default:   match = 1'b0;
    endcase
  end

  // Encoding 3 falls back to a read; a write needs R as well since W-without-R is reserved.
  always_comb begin
    w_perm = cfg.r;
    case (acc)
      ACC_W:   w_perm = cfg.w & cfg.r;
      ACC_X:   w_perm = cfg.x;
      default: w_perm = cfg.r;
    endcase
    perm_ok = (priv_m && !cfg.l) || w_perm;
  end

endmodule

// File: rtl/pmp_serial_checker.sv
// Serial PMP checker: walks one pmpcfg/pmpaddr entry per cycle and reports allow/fault and the lowest match.
module pmp_serial_checker
  import pmp_types_1_12_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  pmp_serial_checker_if.slave  bus,
  output logic [5:0]           cfg_rd_idx,
  input  logic [7:0]           cfg_rd_cfg,
  input  logic [31:0]          cfg_rd_addr
);

  pmp_fsm_t         r_state;
  pmp_fsm_t         w_next;
  logic [IDX_W-1:0] r_idx;
  pmpaddr_t         r_prev_addr;
  logic [29:0]      r_word;
  logic [1:0]       r_acc;
  logic             r_priv_m;
  logic             r_resp_valid;
  logic             r_resp_fault;
  logic             r_resp_match;
  logic [IDX_W-1:0] r_resp_idx;

  logic             w_match;
  logic             w_perm_ok;
  logic             w_last;
  logic             w_hs;
  logic [31:0]      w_a;

  assign w_a    = {2'b00, r_word};
  assign w_last = (r_idx == IDX_W'(NUM_ENTRIES - 1));
  assign w_hs   = r_resp_valid && bus.resp_ready;

  pmp_entry_match u_match (
    .a         (w_a),
    .prev_addr (r_prev_addr),
    .cfg       (pmpcfg_base_t'(cfg_rd_cfg)),
    .pmpaddr   (cfg_rd_addr),
    .acc       (r_acc),
    .priv_m    (r_priv_m),
    .match     (w_match),
    .perm_ok   (w_perm_ok)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid)       w_next = SCAN;
      SCAN:    if (w_match || w_last)   w_next = RESP;
      RESP:    if (w_hs)                w_next = IDLE;
      default:                          w_next = IDLE;
    endcase
  end

  // The result lands on entering RESP; resp_valid rises one edge later, so a match at entry k
  // is visible after edge k+2 of the accepting edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx        <= '0;
      r_prev_addr  <= '0;
      r_word       <= '0;
      r_acc        <= '0;
      r_priv_m     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_match <= 1'b0;
      r_resp_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_word      <= bus.req_addr[31:2];
            r_acc       <= bus.req_acc;
            r_priv_m    <= bus.req_priv_m;
            r_idx       <= '0;
            r_prev_addr <= '0;
          end
        end
        SCAN: begin
          if (w_match || w_last) begin
            r_resp_match <= w_match;
            r_resp_idx   <= w_match ? r_idx : '0;
            r_resp_fault <= w_match ? !w_perm_ok : !r_priv_m;
          end else begin
            r_prev_addr <= cfg_rd_addr;
            r_idx       <= r_idx + 1'b1;
          end
        end
        RESP: begin
          r_resp_valid <= !w_hs;
        end
        default: r_resp_valid <= 1'b0;
      endcase
    end
  end

  assign cfg_rd_idx      = 6'(r_idx);
  assign bus.req_ready   = (r_state == IDLE) && !RST;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_fault  = r_resp_fault;
  assign bus.resp_match  = r_resp_match;
  assign bus.resp_idx    = r_resp_idx;

endmodule

// File: doc/pmp_serial_checker.md
Name: pmp_serial_checker

Overview:
- Reader side of the PMP CSR file: takes one physical-address access request and walks pmpcfg/pmpaddr entries one per cycle through a read port.
- Returns allow/fault plus the matching entry index.
- Sits between the memory-request path (fetch/LSU) and the PMP CSR storage; trades latency for area versus a fully parallel checker.

Parameters:
- NUM_ENTRIES, 16, number of implemented PMP entries; legal 1..64.
- IDX_W, $clog2(NUM_ENTRIES) (min 1), width of resp_idx.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  checker idle, can accept.
- req_addr  in  32  physical byte address (word-aligned access assumed; base address only checked).
- req_acc  in  2  pmp_access_t: ACC_R=0, ACC_W=1, ACC_X=2.
- req_priv_m  in  1  1 = machine mode, 0 = S/U.
- cfg_rd_idx  out  6  entry index being read.
- cfg_rd_cfg  in  8  pmpcfg_base_t of entry cfg_rd_idx, same-cycle combinational.
- cfg_rd_addr  in  32  pmpaddr_t of entry cfg_rd_idx, same-cycle combinational.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_fault  out  1  access-fault.
- resp_match  out  1  some entry matched.
- resp_idx  out  IDX_W  lowest matching entry (0 when no match).

Behaviour:
- Async reset: state=IDLE, scan index=0, prev_addr=0, resp_valid=0, resp_fault=0, resp_match=0, resp_idx=0, cfg_rd_idx=0. req_ready is 1 once RST deasserts.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/acc/priv, idx<=0, prev_addr<=0, go to SCAN.
- SCAN:
  - req_ready=0; cfg_rd_idx=idx.
  - Compare word address a={2'b00,req_addr[31:2]} against entry idx.
  - Mode OFF: no match.
  - TOR: prev_addr <= a < cfg_rd_addr, unsigned. Entry 0 uses prev_addr=0. If prev_addr >= cfg_rd_addr, no match.
  - NA4: a == cfg_rd_addr.
  - NAPOT: m = cfg_rd_addr ^ (cfg_rd_addr+1). Match if (a & ~m) == (cfg_rd_addr & ~m). All-ones pmpaddr matches everything.
  - On match: register result, go to RESP.
  - Else, if idx==NUM_ENTRIES-1: register no-match result, go to RESP.
  - Else: prev_addr<=cfg_rd_addr, idx<=idx+1.
- Permission on match:
  - perm = (ACC_R:R, ACC_W:W&R, ACC_X:X). W with R=0 is reserved and is denied.
  - If req_priv_m and L=0: allow.
  - Otherwise fault = ~perm.
- No match: fault = ~req_priv_m.
- RESP:
  - resp_valid=1. All resp_* fields are stable until the resp_valid&resp_ready cycle; then go to IDLE.
  - req_ready=0, so there is no back-to-back overlap. The next request can be accepted the cycle after the handshake.
- Latency: request accepted at edge 0 with a match at entry k gives resp_valid high after edge k+2. No match gives NUM_ENTRIES+1.
- Reserved cfg bits [6:5] are ignored. req_acc=3 is treated as ACC_R.
- CSR values are read live each SCAN cycle. The core does not write PMP CSRs while a check is outstanding; no snapshotting is done.
- RST mid-SCAN/RESP: outputs go to reset values immediately; no response for the aborted request after release.

Decomposition:
- Add to pmp_types_1_12_pkg:
  - pmp_access_t enum (2 bits).
  - pmp_fsm_t enum {IDLE, SCAN, RESP}.
  - Function pmp_napot_mask(pmpaddr_t).
- One combinational sub-module, pmp_entry_match:
  - Inputs: a, prev_addr, cfg, pmpaddr, acc, priv_m.
  - Outputs: match, perm_ok.
  - Reused later by a parallel checker.

Test Plan:
- NAPOT allow/deny:
  - Setup: entry0 cfg=0x19 (NAPOT, R), pmpaddr0=0x2000_01FF (region 0x8000_0000..0x8000_0FFF); U-mode.
  - Load 0x8000_0FFC -> match=1, idx=0, fault=0, resp_valid after edge 2.
  - Store to the same address -> fault=1.
  - Load 0x8000_1000 -> match=0, fault=1 at edge 17.
- TOR:
  - Setup: entries0-2 OFF, pmpaddr2=0x0400_0000, pmpaddr3=0x0400_0400, cfg3=0x0D (TOR, X, R); U-mode fetch.
  - Fetch 0x1000_0FFC -> idx=3, fault=0, resp_valid after edge 5.
  - Fetch 0x1000_1000 -> no match, fault=1.
- M-mode and lock:
  - Entry0 cfg=0x19, M-mode store -> fault=0.
  - cfg=0x99 (L=1), M-mode store -> fault=1.
  - M-mode access to an unmatched address -> fault=0.
  - Reserved cfg=0x1A (W only), U-mode store -> fault=1.
- Priority: entry1 NA4 R-only and entry5 NAPOT RWX both cover 0x0000_0100; U-mode store -> idx=1, fault=1, response after edge 3.
- Backpressure: hold resp_ready=0 for 3 cycles with req_valid=1 -> resp_* stable, req_ready=0, second request accepted only the cycle after the handshake.
- Reset mid-SCAN: assert RST at the cycle idx=4 -> resp_valid=0 and req_ready=0 immediately; after release, req_ready=1 and no stale response appears.
